// File: rtl/mem_addr_iterator_pkg.sv
// Shared constants, FSM encoding and lane helpers for the LD/ST memory stage-1 address iterator.
package mem_pkg;
  localparam int NUM_THREADS = 8;
  localparam int BLK_OFS_W   = 5;
  localparam int LANE_W      = 32;
  localparam int BLK_ADDR_W  = LANE_W - BLK_OFS_W;
  localparam int IDX_W       = $clog2(NUM_THREADS);
  localparam int BUS_W       = NUM_THREADS * LANE_W;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } iter_state_e;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                   input logic [IDX_W-1:0] idx);
    return bus[idx*LANE_W +: LANE_W];
  endfunction

  function automatic logic [BLK_ADDR_W-1:0] blk_of(input logic [LANE_W-1:0] addr);
    return addr[LANE_W-1:BLK_OFS_W];
  endfunction
endpackage

// File: rtl/mem_addr_iterator_if.sv
// Bundle between the AGU / memory stage 2 and the stage-1 address iterator.
interface mem_addr_iterator_if;
  import mem_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  shared_global_bar;
  logic [2:0]            warp_ID;
  logic [1:0]            scb_ID;
  logic [4:0]            reg_addr;
  logic [31:0]           Instr;
  logic [NUM_THREADS-1:0] PAM;
  logic [BUS_W-1:0]      eff_addr;
  logic [BUS_W-1:0]      write_data;
  logic                  stall_i;
  logic                  out_valid;
  logic                  MemRead_o;
  logic                  MemWrite_o;
  logic                  shared_global_bar_o;
  logic [2:0]            warp_ID_o;
  logic [1:0]            scb_ID_o;
  logic [4:0]            reg_addr_o;
  logic [31:0]           Instr_o;
  logic [NUM_THREADS-1:0] PAM_o;
  logic [BUS_W-1:0]      eff_addr_o;
  logic [BUS_W-1:0]      write_data_o;
  logic [BLK_ADDR_W-1:0] addr_sel;
  logic                  last_o;

  // Handshake: an instruction transfers on every cycle with in_valid && in_ready; a pass
  // transfers on every cycle with out_valid && !stall_i, and pass outputs hold while stall_i is high.
  modport slave (
    input  in_valid, MemRead, MemWrite, shared_global_bar, warp_ID, scb_ID, reg_addr,
           Instr, PAM, eff_addr, write_data, stall_i,
    output in_ready, out_valid, MemRead_o, MemWrite_o, shared_global_bar_o, warp_ID_o,
           scb_ID_o, reg_addr_o, Instr_o, PAM_o, eff_addr_o, write_data_o, addr_sel, last_o
  );

  modport master (
    output in_valid, MemRead, MemWrite, shared_global_bar, warp_ID, scb_ID, reg_addr,
           Instr, PAM, eff_addr, write_data, stall_i,
    input  in_ready, out_valid, MemRead_o, MemWrite_o, shared_global_bar_o, warp_ID_o,
           scb_ID_o, reg_addr_o, Instr_o, PAM_o, eff_addr_o, write_data_o, addr_sel, last_o
  );
endinterface

// File: rtl/mem_addr_iterator_pick_first.sv
// Priority encoder: index of the lowest set bit of the remaining-thread mask.
module mem_pick_first
  import mem_pkg::*;
(
  input  logic [NUM_THREADS-1:0] i_remaining,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (i_remaining[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_addr_iterator.sv
// Memory stage 1: serialises one warp instruction into one pass per distinct 32-byte block.
// Optional MEM_ITER_PERF_EN adds perf_passes / perf_instrs counters.
module mem_addr_iterator
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetb,
  mem_addr_iterator_if.slave    bus,
  output iter_state_e           o_dbg_state
`ifdef MEM_ITER_PERF_EN
  ,
  output logic [31:0]           perf_passes,
  output logic [31:0]           perf_instrs
`endif
);
  iter_state_e            r_state;
  logic [NUM_THREADS-1:0] r_remaining;
  logic                   r_mr, r_mw, r_sgb;
  logic [2:0]             r_warp;
  logic [1:0]             r_scb;
  logic [4:0]             r_reg;
  logic [31:0]            r_instr;
  logic [NUM_THREADS-1:0] r_pam;
  logic [BUS_W-1:0]       r_eff, r_wd;

  logic                   r_out_valid, r_mr_o, r_mw_o, r_sgb_o, r_last;
  logic [2:0]             r_warp_o;
  logic [1:0]             r_scb_o;
  logic [4:0]             r_reg_o;
  logic [31:0]            r_instr_o;
  logic [NUM_THREADS-1:0] r_pam_o;
  logic [BUS_W-1:0]       r_eff_o, r_wd_o;
  logic [BLK_ADDR_W-1:0]  r_addr_sel;

  logic [IDX_W-1:0]       w_k;
  logic                   w_any;
  logic [BLK_ADDR_W-1:0]  w_blk;
  logic [NUM_THREADS-1:0] w_rem_next;
  logic                   w_pass_done;
  logic                   w_in_ready;
  logic                   w_accept;

  mem_pick_first u_pick (
    .i_remaining (r_remaining),
    .o_idx       (w_k),
    .o_any       (w_any)
  );

  // An empty mask still yields one pass, reported as block 0 so stage 2 can release.
  always_comb begin
    w_blk      = w_any ? blk_of(lane_slice(r_eff, w_k)) : '0;
    w_rem_next = r_remaining;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (blk_of(lane_slice(r_eff, IDX_W'(i))) == w_blk) w_rem_next[i] = 1'b0;
    end
  end

  assign w_pass_done = (w_rem_next == '0);
  assign w_in_ready  = (r_state == IDLE) || (!bus.stall_i && w_pass_done);
  assign w_accept    = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_mr        <= 1'b0;
      r_mw        <= 1'b0;
      r_sgb       <= 1'b0;
      r_warp      <= '0;
      r_scb       <= '0;
      r_reg       <= '0;
      r_instr     <= '0;
      r_pam       <= '0;
      r_eff       <= '0;
      r_wd        <= '0;
      r_out_valid <= 1'b0;
      r_mr_o      <= 1'b0;
      r_mw_o      <= 1'b0;
      r_sgb_o     <= 1'b0;
      r_last      <= 1'b0;
      r_warp_o    <= '0;
      r_scb_o     <= '0;
      r_reg_o     <= '0;
      r_instr_o   <= '0;
      r_pam_o     <= '0;
      r_eff_o     <= '0;
      r_wd_o      <= '0;
      r_addr_sel  <= '0;
    end else begin
      case (r_state)
        IDLE: if (!bus.stall_i) r_out_valid <= 1'b0;
        ITER: if (!bus.stall_i) begin
          r_out_valid <= 1'b1;
          r_addr_sel  <= w_blk;
          r_last      <= w_pass_done;
          r_mr_o      <= r_mr && w_any;
          r_mw_o      <= r_mw && w_any;
          r_sgb_o     <= r_sgb;
          r_warp_o    <= r_warp;
          r_scb_o     <= r_scb;
          r_reg_o     <= r_reg;
          r_instr_o   <= r_instr;
          r_pam_o     <= r_pam;
          r_eff_o     <= r_eff;
          r_wd_o      <= r_wd;
          r_remaining <= w_rem_next;
          if (w_pass_done && !bus.in_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Capture overrides the ITER update so the next instruction starts without a bubble.
      if (w_accept) begin
        r_state     <= ITER;
        r_remaining <= bus.PAM;
        r_mr        <= bus.MemRead;
        r_mw        <= bus.MemWrite;
        r_sgb       <= bus.shared_global_bar;
        r_warp      <= bus.warp_ID;
        r_scb       <= bus.scb_ID;
        r_reg       <= bus.reg_addr;
        r_instr     <= bus.Instr;
        r_pam       <= bus.PAM;
        r_eff       <= bus.eff_addr;
        r_wd        <= bus.write_data;
      end
    end
  end

`ifdef MEM_ITER_PERF_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      perf_passes <= '0;
      perf_instrs <= '0;
    end else begin
      if (r_state == ITER && !bus.stall_i) perf_passes <= perf_passes + 32'd1;
      if (w_accept) perf_instrs <= perf_instrs + 32'd1;
    end
  end
`endif

  assign bus.in_ready            = w_in_ready;
  assign bus.out_valid           = r_out_valid;
  assign bus.MemRead_o           = r_mr_o;
  assign bus.MemWrite_o          = r_mw_o;
  assign bus.shared_global_bar_o = r_sgb_o;
  assign bus.warp_ID_o           = r_warp_o;
  assign bus.scb_ID_o            = r_scb_o;
  assign bus.reg_addr_o          = r_reg_o;
  assign bus.Instr_o             = r_instr_o;
  assign bus.PAM_o               = r_pam_o;
  assign bus.eff_addr_o          = r_eff_o;
  assign bus.write_data_o        = r_wd_o;
  assign bus.addr_sel            = r_addr_sel;
  assign bus.last_o              = r_last;
  assign o_dbg_state             = r_state;
endmodule

// File: tb/tb_mem_addr_iterator.sv
// Bench for mem_addr_iterator: directed scenarios plus randomized traffic against a block-list model.
module tb_mem_addr_iterator;
  import mem_pkg::*;

  localparam int REC_W = 593;

  logic        clk = 1'b0;
  logic        resetb;
  iter_state_e dbg_state;
  int          checks = 0;
  int          failures = 0;
  logic [REC_W-1:0] exp_q[$];

  mem_addr_iterator_if bus ();
`ifdef MEM_ITER_PERF_EN
  logic [31:0] perf_passes, perf_instrs;
`endif

  mem_addr_iterator dut (
    .clk         (clk),
    .resetb      (resetb),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef MEM_ITER_PERF_EN
    ,
    .perf_passes (perf_passes),
    .perf_instrs (perf_instrs)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.shared_global_bar = 1'b0; bus.warp_ID = '0; bus.scb_ID = '0;
    bus.reg_addr = '0; bus.Instr = '0; bus.PAM = '0;
    bus.eff_addr = '0; bus.write_data = '0; bus.stall_i = 1'b0;
  endtask

  task automatic set_instr(input logic mr, input logic mw, input logic sgb,
                           input logic [2:0] warp, input logic [1:0] scb, input logic [4:0] rg,
                           input logic [31:0] ins, input logic [7:0] pam,
                           input logic [255:0] eff, input logic [255:0] wd);
    bus.MemRead = mr; bus.MemWrite = mw; bus.shared_global_bar = sgb;
    bus.warp_ID = warp; bus.scb_ID = scb; bus.reg_addr = rg; bus.Instr = ins;
    bus.PAM = pam; bus.eff_addr = eff; bus.write_data = wd; bus.in_valid = 1'b1;
  endtask

  function automatic logic [255:0] lanes_lin(input logic [31:0] base, input logic [31:0] stride);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = base + stride * i;
    return v;
  endfunction

  function automatic logic [REC_W-1:0] pack(input logic [26:0] a, input logic l, input logic mr,
      input logic mw, input logic sgb, input logic [2:0] warp, input logic [1:0] scb,
      input logic [4:0] rg, input logic [31:0] ins, input logic [7:0] pam,
      input logic [255:0] eff, input logic [255:0] wd);
    return {a, l, mr, mw, sgb, warp, scb, rg, ins, pam, eff, wd};
  endfunction

  // Reference: one pass per distinct block among active lanes, in order of first appearance.
  task automatic push_model(input logic mr, input logic mw, input logic sgb, input logic [2:0] warp,
                            input logic [1:0] scb, input logic [4:0] rg, input logic [31:0] ins,
                            input logic [7:0] pam, input logic [255:0] eff, input logic [255:0] wd);
    logic [26:0] blks[$];
    logic [31:0] a;
    bit seen;
    if (pam == 8'h00) begin
      exp_q.push_back(pack(27'h0, 1'b1, 1'b0, 1'b0, sgb, warp, scb, rg, ins, 8'h00, eff, wd));
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pam[i]) begin
          a = eff[32*i +: 32];
          seen = 0;
          foreach (blks[j]) if (blks[j] == a / 32) seen = 1;
          if (!seen) blks.push_back(27'(a / 32));
        end
      end
      foreach (blks[j])
        exp_q.push_back(pack(blks[j], j == blks.size() - 1, mr, mw, sgb, warp, scb, rg, ins,
                             pam, eff, wd));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    resetb = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.addr_sel !== 27'h0 || bus.last_o !== 1'b0 || bus.PAM_o !== 8'h0) begin failures++; $display("FAIL rst_outputs addr=%h last=%b pam=%h exp=0", bus.addr_sel, bus.last_o, bus.PAM_o); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_same_block();
    set_instr(1, 0, 0, 3'd1, 2'd1, 5'd3, 32'hA5A5_0001, 8'hFF, lanes_lin(32'h2000, 4), {8{32'h1111_2222}});
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL same_ready_idle got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL same_latency got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h100 || bus.last_o !== 1'b1) begin failures++; $display("FAIL same_pass v=%b addr=%h last=%b exp 1/100/1", bus.out_valid, bus.addr_sel, bus.last_o); end
    checks++; if (bus.MemRead_o !== 1'b1 || bus.PAM_o !== 8'hFF || bus.Instr_o !== 32'hA5A5_0001) begin failures++; $display("FAIL same_ctx mr=%b pam=%h ins=%h", bus.MemRead_o, bus.PAM_o, bus.Instr_o); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL same_ready_after got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL same_drop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_divergent();
    set_instr(0, 1, 1, 3'd5, 2'd2, 5'd9, 32'h0000_BEEF, 8'hFF, lanes_lin(32'h1000, 32'h20), lanes_lin(32'h7, 1));
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'(32'h80 + i) || bus.last_o !== (i == 7)) begin
        failures++; $display("FAIL div_pass%0d v=%b addr=%h last=%b exp addr=%h", i, bus.out_valid, bus.addr_sel, bus.last_o, 32'h80 + i);
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL div_drop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_inactive_lanes();
    logic [255:0] eff;
    eff = {8{32'h9000}};
    eff[31:0] = 32'h40; eff[255:224] = 32'h40;
    set_instr(1, 0, 1, 3'd2, 2'd0, 5'd1, 32'h1234_5678, 8'h81, eff, '0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h2 || bus.last_o !== 1'b1 || bus.PAM_o !== 8'h81) begin failures++; $display("FAIL inact_pass v=%b addr=%h last=%b pam=%h exp 1/2/1/81", bus.out_valid, bus.addr_sel, bus.last_o, bus.PAM_o); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL inact_single got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_stall();
    logic [255:0] eff;
    for (int i = 0; i < 8; i++) eff[32*i +: 32] = (i < 4) ? 32'(4 * i) : 32'(32'h20 + 4 * i);
    set_instr(1, 0, 0, 3'd3, 2'd3, 5'd7, 32'h5555_0000, 8'hFF, eff, '0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h0 || bus.last_o !== 1'b0) begin failures++; $display("FAIL stall_pass1 v=%b addr=%h last=%b exp 1/0/0", bus.out_valid, bus.addr_sel, bus.last_o); end
    bus.stall_i = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h0 || bus.last_o !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d v=%b addr=%h last=%b rdy=%b exp 1/0/0/0", c, bus.out_valid, bus.addr_sel, bus.last_o, bus.in_ready);
      end
    end
    bus.stall_i = 1'b0;
    set_instr(0, 1, 0, 3'd4, 2'd1, 5'd2, 32'h6666_0000, 8'hFF, lanes_lin(32'h2000, 4), '0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_last got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h1 || bus.last_o !== 1'b1) begin failures++; $display("FAIL stall_pass2 v=%b addr=%h last=%b exp 1/1/1", bus.out_valid, bus.addr_sel, bus.last_o); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.addr_sel !== 27'h100 || bus.Instr_o !== 32'h6666_0000) begin failures++; $display("FAIL b2b_next v=%b addr=%h ins=%h exp 1/100/66660000", bus.out_valid, bus.addr_sel, bus.Instr_o); end
    tick();
  endtask

  task automatic test_zero_pam();
    set_instr(1, 0, 1, 3'd6, 2'd2, 5'd4, 32'h0F0F_0F0F, 8'h00, lanes_lin(32'h3000, 32'h40), '0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.MemRead_o !== 1'b0 || bus.MemWrite_o !== 1'b0 || bus.last_o !== 1'b1) begin failures++; $display("FAIL zpam_pass v=%b mr=%b mw=%b last=%b exp 1/0/0/1", bus.out_valid, bus.MemRead_o, bus.MemWrite_o, bus.last_o); end
    checks++; if (bus.addr_sel !== 27'h0 || bus.PAM_o !== 8'h00 || bus.warp_ID_o !== 3'd6) begin failures++; $display("FAIL zpam_ctx addr=%h pam=%h warp=%0d exp 0/0/6", bus.addr_sel, bus.PAM_o, bus.warp_ID_o); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL zpam_single got=%b exp=0", bus.out_valid); end
  endtask

`ifdef MEM_ITER_PERF_EN
  task automatic test_perf();
    checks++; if (perf_passes !== 32'd14 || perf_instrs !== 32'd6) begin failures++; $display("FAIL perf passes=%0d instrs=%0d exp 14/6", perf_passes, perf_instrs); end
  endtask
`endif

  task automatic test_reset_mid();
    set_instr(1, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 8'hFF, lanes_lin(32'h1000, 32'h20), '0);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.addr_sel !== 27'h82) begin failures++; $display("FAIL rmid_pass3 addr=%h exp=82", bus.addr_sel); end
    resetb = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== IDLE) begin failures++; $display("FAIL rmid_abort v=%b rdy=%b st=%0d exp 0/1/0", bus.out_valid, bus.in_ready, dbg_state); end
    tick();
    resetb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_residual%0d v=%b rdy=%b exp 0/1", c, bus.out_valid, bus.in_ready); end
    end
  endtask

  task automatic test_random();
    localparam int N_INSTR = 150;
    int accepted = 0;
    int cyc = 0;
    bit offering = 0;
    logic stall;
    logic [26:0] base;
    logic [REC_W-1:0] got, e;
    logic mr, mw, sgb;
    logic [2:0] warp; logic [1:0] scb; logic [4:0] rg; logic [31:0] ins; logic [7:0] pam;
    logic [255:0] eff, wd;
    exp_q.delete();
    while ((accepted < N_INSTR || offering || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      if (!offering && accepted < N_INSTR && $urandom_range(0, 2) != 0) begin
        mr = 1'($urandom); mw = ~mr; sgb = 1'($urandom);
        warp = 3'($urandom); scb = 2'($urandom); rg = 5'($urandom); ins = $urandom;
        pam = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        base = 27'($urandom);
        for (int i = 0; i < 8; i++) begin
          eff[32*i +: 32] = {27'(base + $urandom_range(0, 3)), 5'($urandom)};
          wd[32*i +: 32] = $urandom;
        end
        set_instr(mr, mw, sgb, warp, scb, rg, ins, pam, eff, wd);
        offering = 1;
      end
      bus.in_valid = offering;
      bus.stall_i = stall;
      #1;
      if (bus.out_valid && !stall) begin
        checks++;
        got = pack(bus.addr_sel, bus.last_o, bus.MemRead_o, bus.MemWrite_o, bus.shared_global_bar_o,
                   bus.warp_ID_o, bus.scb_ID_o, bus.reg_addr_o, bus.Instr_o, bus.PAM_o,
                   bus.eff_addr_o, bus.write_data_o);
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra_pass addr=%h last=%b", bus.addr_sel, bus.last_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL rnd_pass cyc=%0d got=%h exp=%h", cyc, got[REC_W-1:512], e[REC_W-1:512]);
          end
        end
      end
      if (offering && bus.in_ready) begin
        push_model(mr, mw, sgb, warp, scb, rg, ins, pam, eff, wd);
        offering = 0;
        accepted++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0; bus.stall_i = 1'b0;
    checks++; if (exp_q.size() != 0 || accepted != N_INSTR) begin failures++; $display("FAIL rnd_drain left=%0d accepted=%0d cyc=%0d", exp_q.size(), accepted, cyc); end
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rnd_quiet got=%b exp=0", bus.out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_same_block();
    test_divergent();
    test_inactive_lanes();
    test_stall();
    test_zero_pam();
`ifdef MEM_ITER_PERF_EN
    test_perf();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
